// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// One bit per cycle; start/busy/done handshake so the control unit can stall on a pending result.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dato_A,
  input  logic [WIDTH-1:0] dato_B,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t             state, state_next;
  logic [5:0]         cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_take;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, remv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // op[0]=1 selects the unsigned variants, so sign handling only applies when op[0]=0.
  always_comb begin
    a_neg     = ~op[0] & dato_A[WIDTH-1];
    b_neg     = ~op[0] & dato_B[WIDTH-1];
    a_abs     = a_neg ? -dato_A : dato_A;
    b_abs     = b_neg ? -dato_B : dato_B;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_take  = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remv      = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_q        <= '0;
      a_orig      <= '0;
      opnd        <= '0;
      acc         <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            a_orig <= dato_A;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (dato_B == '0);
            cnt    <= '0;
            rem    <= '0;
            busy   <= 1'b1;
            // Divide keeps the dividend in acc's low half and shifts quotient bits in behind it.
            if (op[1]) begin
              opnd <= b_abs;
              acc  <= {{WIDTH{1'b0}}, a_abs};
            end else begin
              opnd <= a_abs;
              acc  <= {{WIDTH{1'b0}}, b_abs};
            end
          end else begin
            if (hi_wr) hi <= write_data;
            if (lo_wr) lo <= write_data;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (op_q[1]) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_take};
            rem            <= div_take ? div_diff : div_shift[WIDTH-1:0];
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (op_q[1]) begin
            if (b_zero) begin
              lo          <= '1;
              hi          <= a_orig;
              div_by_zero <= 1'b1;
            end else begin
              lo          <= quo;
              hi          <= remv;
              div_by_zero <= 1'b0;
            end
          end else begin
            {hi, lo}    <= prod;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
